// File: rtl/conv_forward_stream.sv
// conv_forward_stream
//   Streaming fp32 dot-product engine: out = sum(in_data[i]*weight_vec[i]) + bias_term,
//   with optional ReLU. Accepts one vector per clock and has a fixed pipeline latency of
//   L = MULT_DELAY + ADD_DELAY*(log2(WIDTH)+1) + 1. The pipeline cannot stall, so a
//   credit counter (in_flight) throttles in_ready and guarantees the output FIFO
//   always has room for every result still in the pipe.
//   Arithmetic: fp32, denormals flushed to zero, truncating rounding, NaN -> 7FC00000.
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake; in_id, relu_en, in_data, weight_vec,
//                              bias_term sampled on accept
//   out_valid/out_ready        output handshake (FWFT FIFO); out_id, out_data
//   in_flight                  vectors accepted but not yet delivered
module conv_forward_stream #(
  parameter int WIDTH      = 8,
  parameter int MULT_DELAY = 5,
  parameter int ADD_DELAY  = 7,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ID_W-1:0]                 in_id,
  input  logic                            relu_en,
  input  logic [32*WIDTH-1:0]             in_data,
  input  logic [32*WIDTH-1:0]             weight_vec,
  input  logic [31:0]                     bias_term,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ID_W-1:0]                 out_id,
  output logic [31:0]                     out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] in_flight
);
  localparam int LOG2W  = $clog2(WIDTH);
  localparam int L      = MULT_DELAY + ADD_DELAY*(LOG2W+1) + 1;
  localparam int BIAS_D = MULT_DELAY + ADD_DELAY*LOG2W;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  if (FIFO_DEPTH < L) begin : g_chk_depth
    $error("conv_forward_stream: FIFO_DEPTH must be >= pipeline latency");
  end
  if (WIDTH < 2 || (WIDTH & (WIDTH-1)) != 0) begin : g_chk_width
    $error("conv_forward_stream: WIDTH must be a power of two >= 2");
  end

  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    logic s;
    logic [24:0] ph;
    logic [9:0] e;
    logic [22:0] m;
    s  = x[31] ^ y[31];
    // Only the top 25 product bits matter with truncating rounding.
    ph = 25'((48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]})) >> 23);
    e  = {2'b0, x[30:23]} + {2'b0, y[30:23]};
    if (ph[24]) begin
      e = e + 10'd1;
      m = ph[23:1];
    end else begin
      m = ph[22:0];
    end
    if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
        (x[30:23] == 8'hFF && y[30:23] == 8'h00) || (y[30:23] == 8'hFF && x[30:23] == 8'h00))
      return QNAN;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF || e >= 10'd382) return {s, 8'hFF, 23'd0};
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00 || e <= 10'd127) return {s, 31'd0};
    e = e - 10'd127;
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [26:0] ma, mb;
    logic [27:0] s;
    logic [9:0] e;
    logic [7:0] d;
    int lz;
    if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0))
      return QNAN;
    if (x[30:23] == 8'hFF) return (y[30:23] == 8'hFF && x[31] != y[31]) ? QNAN : x;
    if (y[30:23] == 8'hFF) return y;
    if (x[30:23] == 8'h00) return (y[30:23] == 8'h00) ? {x[31] & y[31], 31'd0} : y;
    if (y[30:23] == 8'h00) return x;
    if (x[30:0] >= y[30:0]) begin
      a = x; b = y;
    end else begin
      a = y; b = x;
    end
    d  = a[30:23] - b[30:23];
    ma = {1'b1, a[22:0], 3'b000};
    mb = (d > 8'd26) ? 27'd0 : ({1'b1, b[22:0], 3'b000} >> d);
    e  = {2'b0, a[30:23]};
    if (a[31] == b[31]) begin
      s = {1'b0, ma} + {1'b0, mb};
      if (s[27]) begin
        s = s >> 1;
        e = e + 10'd1;
      end
      if (e >= 10'd255) return {a[31], 8'hFF, 23'd0};
      return {a[31], e[7:0], s[25:3]};
    end
    s = {1'b0, ma} - {1'b0, mb};
    if (s == 28'd0) return 32'd0;
    lz = 0;
    for (int i = 0; i <= 26; i++) if (s[i]) lz = 26 - i;
    if (int'(e) <= lz) return {a[31], 31'd0};
    s = s << lz;
    e = e - 10'(lz);
    return {a[31], e[7:0], s[25:3]};
  endfunction

  // Datapath: no reset on data registers, only the valid chain is cleared.
  logic [31:0] w_prod [WIDTH];
  logic [31:0] r_mul  [MULT_DELAY][WIDTH];
  // Adder tree nodes packed level by level: level k starts at WIDTH - (WIDTH >> (k-1)),
  // the root sits at WIDTH-2.
  logic [31:0] w_node [WIDTH-1];
  logic [31:0] r_node [ADD_DELAY][WIDTH-1];
  logic [31:0] r_bias [BIAS_D];
  logic [31:0] w_biased;
  logic [31:0] r_bsum [ADD_DELAY];
  logic [31:0] r_res;
  logic [31:0] w_relu;
  logic [ID_W-1:0] r_id [L];
  logic [L-2:0] r_relu;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mul
    assign w_prod[i] = fmul(in_data[32*i +: 32], weight_vec[32*i +: 32]);
  end

  for (genvar k = 1; k <= LOG2W; k++) begin : g_lvl
    localparam int OFF = WIDTH - (WIDTH >> (k-1));
    for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_node
      if (k == 1) begin : g_leaf
        assign w_node[OFF+j] = fadd(r_mul[MULT_DELAY-1][2*j], r_mul[MULT_DELAY-1][2*j+1]);
      end else begin : g_inner
        localparam int PREV = WIDTH - (WIDTH >> (k-2));
        assign w_node[OFF+j] = fadd(r_node[ADD_DELAY-1][PREV+2*j],
                                    r_node[ADD_DELAY-1][PREV+2*j+1]);
      end
    end
  end

  assign w_biased = fadd(r_node[ADD_DELAY-1][WIDTH-2], r_bias[BIAS_D-1]);
  // NaN keeps its sign bit and passes through ReLU untouched.
  assign w_relu = (r_relu[L-2] && r_bsum[ADD_DELAY-1][31] &&
                   !(r_bsum[ADD_DELAY-1][30:23] == 8'hFF && r_bsum[ADD_DELAY-1][22:0] != 23'd0))
                  ? 32'd0 : r_bsum[ADD_DELAY-1];

  always_ff @(posedge clk) begin
    r_mul[0]  <= w_prod;
    for (int s = 1; s < MULT_DELAY; s++) r_mul[s] <= r_mul[s-1];
    r_node[0] <= w_node;
    for (int s = 1; s < ADD_DELAY; s++) r_node[s] <= r_node[s-1];
    r_bias[0] <= bias_term;
    for (int s = 1; s < BIAS_D; s++) r_bias[s] <= r_bias[s-1];
    r_bsum[0] <= w_biased;
    for (int s = 1; s < ADD_DELAY; s++) r_bsum[s] <= r_bsum[s-1];
    r_res     <= w_relu;
    r_id[0]   <= in_id;
    for (int s = 1; s < L; s++) r_id[s] <= r_id[s-1];
    r_relu    <= {r_relu[L-3:0], relu_en};
  end

  // Control: valid chain, credits, output FIFO.
  logic [L-1:0]            r_vld;
  logic                    r_run;
  logic [CNT_W-1:0]        r_in_flight;
  logic [CNT_W-1:0]        r_cnt;
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [ID_W+31:0]        r_mem [FIFO_DEPTH];
  logic                    w_accept, w_wr, w_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = r_run && (r_in_flight < CNT_W'(FIFO_DEPTH));
  assign w_accept  = in_valid && in_ready;
  assign w_wr      = r_vld[L-1];
  assign out_valid = (r_cnt != '0);
  assign w_rd      = out_valid && out_ready;
  assign {out_id, out_data} = out_valid ? r_mem[r_rd_ptr] : '0;
  assign in_flight = r_in_flight;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {r_id[L-1], r_res};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld       <= '0;
      r_run       <= 1'b0;
      r_in_flight <= '0;
      r_cnt       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_vld <= {r_vld[L-2:0], w_accept};
      r_run <= 1'b1;
      if (w_accept && !w_rd)      r_in_flight <= r_in_flight + 1'b1;
      else if (!w_accept && w_rd) r_in_flight <= r_in_flight - 1'b1;
      if (w_wr && !w_rd)          r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_rd)     r_cnt <= r_cnt - 1'b1;
      if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
    end
  end
endmodule

// File: tb/tb_conv_forward_stream.sv
module tb_conv_forward_stream;
  localparam int WIDTH = 8;
  localparam int ID_W  = 8;
  localparam int DEPTH = 64;
  localparam int L     = 34;
  localparam int NSTR  = 100;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [ID_W-1:0]       in_id;
  logic                  relu_en;
  logic [32*WIDTH-1:0]   in_data;
  logic [32*WIDTH-1:0]   weight_vec;
  logic [31:0]           bias_term;
  logic                  out_valid;
  logic                  out_ready;
  logic [ID_W-1:0]       out_id;
  logic [31:0]           out_data;
  logic [6:0]            in_flight;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] st_a   [NSTR][WIDTH];
  logic [31:0] st_w   [NSTR][WIDTH];
  logic [31:0] st_b   [NSTR];
  logic [31:0] st_exp [NSTR];

  conv_forward_stream #(.WIDTH(WIDTH), .MULT_DELAY(5), .ADD_DELAY(7), .ID_W(ID_W),
                        .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .relu_en(relu_en), .in_data(in_data), .weight_vec(weight_vec), .bias_term(bias_term),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
    .in_flight(in_flight));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uniform(input logic [31:0] a, input logic [31:0] w, input logic [31:0] b,
                             input logic [7:0] id, input logic r);
    for (int i = 0; i < WIDTH; i++) begin
      in_data[32*i +: 32]    = a;
      weight_vec[32*i +: 32] = w;
    end
    bias_term = b;
    in_id     = id;
    relu_en   = r;
  endtask

  function automatic logic [31:0] int_to_f32(input int v);
    logic [31:0] u;
    int p;
    if (v == 0) return 32'd0;
    u = v;
    p = 0;
    for (int i = 0; i < 24; i++) if (u[i]) p = i;
    u = u << (23 - p);
    return {1'b0, 8'(127 + p), u[22:0]};
  endfunction

  function automatic real f32_to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(int'(f[30:23]) - 127 + 1023);
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_uniform(32'd0, 32'd0, 32'd0, 8'd0, 1'b0);
    repeat (3) tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_vec++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_vec++; if (out_id !== 8'd0) begin n_err++; $display("FAIL rst_out_id got %h want 0", out_id); end
    n_vec++; if (in_flight !== 7'd0) begin n_err++; $display("FAIL rst_in_flight got %0d want 0", in_flight); end
    reset = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    set_uniform(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 8'h11, 1'b0);
    in_valid = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (in_flight !== 7'd1) begin n_err++; $display("FAIL basic_inflight got %0d want 1", in_flight); end
    repeat (L-1) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got %0b want 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency got %0b want 1", out_valid); end
    n_vec++; if (out_data !== 32'h4184_0000) begin n_err++; $display("FAIL basic_data got %h want 41840000", out_data); end
    n_vec++; if (out_id !== 8'h11) begin n_err++; $display("FAIL basic_id got %h want 11", out_id); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained got %0b want 0", out_valid); end
    n_vec++; if (in_flight !== 7'd0) begin n_err++; $display("FAIL basic_inflight_end got %0d want 0", in_flight); end
  endtask

  task automatic test_relu();
    logic [31:0] exp_d [3];
    logic [7:0]  exp_i [3];
    int got;
    exp_d[0] = 32'hC180_0000; exp_i[0] = 8'h01;
    exp_d[1] = 32'h0000_0000; exp_i[1] = 8'h02;
    exp_d[2] = 32'h7FC0_0000; exp_i[2] = 8'h03;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_uniform(32'h3F80_0000, 32'hC000_0000, 32'd0, 8'h01, 1'b0);
    tick();
    set_uniform(32'h3F80_0000, 32'hC000_0000, 32'd0, 8'h02, 1'b1);
    tick();
    set_uniform(32'h3F80_0000, 32'h4000_0000, 32'd0, 8'h03, 1'b1);
    in_data[31:0] = 32'h7FC0_0000;
    tick();
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got < 3; c++) begin
      if (out_valid) begin
        n_vec++; if (out_data !== exp_d[got]) begin n_err++; $display("FAIL relu_data%0d got %h want %h", got, out_data, exp_d[got]); end
        n_vec++; if (out_id !== exp_i[got]) begin n_err++; $display("FAIL relu_id%0d got %h want %h", got, out_id, exp_i[got]); end
        got++;
      end
      tick();
    end
    n_vec++; if (got !== 3) begin n_err++; $display("FAIL relu_count got %0d want 3", got); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < NSTR; i++) begin
      real acc;
      acc = 0.0;
      for (int j = 0; j < WIDTH; j++) begin
        st_a[i][j] = {1'b0, 8'(126 + $urandom_range(0, 2)), 23'($urandom)};
        st_w[i][j] = {1'b0, 8'(126 + $urandom_range(0, 2)), 23'($urandom)};
        acc = acc + f32_to_real(st_a[i][j]) * f32_to_real(st_w[i][j]);
      end
      st_b[i]   = {1'b0, 8'(126 + $urandom_range(0, 2)), 23'($urandom)};
      st_exp[i] = real_to_f32(acc + f32_to_real(st_b[i]));
    end
    out_ready = 1'b1;
    fork
      begin
        int i;
        logic acc_ok;
        i = 0;
        for (int c = 0; c < 400 && i < NSTR; c++) begin
          for (int j = 0; j < WIDTH; j++) begin
            in_data[32*j +: 32]    = st_a[i][j];
            weight_vec[32*j +: 32] = st_w[i][j];
          end
          bias_term = st_b[i]; in_id = 8'(i); relu_en = 1'b0; in_valid = 1'b1;
          acc_ok = in_ready;
          tick();
          if (acc_ok) i++;
        end
        in_valid = 1'b0;
      end
      begin
        int waited;
        longint diff;
        waited = 0;
        while (!out_valid && waited < 300) begin tick(); waited++; end
        for (int k = 0; k < NSTR; k++) begin
          n_vec++;
          if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL stream_bubble%0d got %0b want 1", k, out_valid);
          end else begin
            n_vec++; if (out_id !== 8'(k)) begin n_err++; $display("FAIL stream_id%0d got %0d want %0d", k, out_id, k); end
            diff = longint'(out_data) - longint'(st_exp[k]);
            if (diff < 0) diff = -diff;
            n_vec++; if (diff > 255) begin n_err++; $display("FAIL stream_ulp%0d got %h want %h", k, out_data, st_exp[k]); end
          end
          tick();
        end
      end
    join
    out_ready = 1'b0;
    n_vec++; if (in_flight !== 7'd0) begin n_err++; $display("FAIL stream_inflight got %0d want 0", in_flight); end
  endtask

  task automatic test_backpressure();
    int acc_cnt, changes, got;
    logic acc_ok, seen;
    logic [31:0] held;
    acc_cnt = 0; changes = 0; seen = 1'b0; held = 32'd0;
    out_ready = 1'b0;
    for (int c = 0; c < 120; c++) begin
      set_uniform(32'h3F80_0000, 32'h4000_0000, int_to_f32(acc_cnt), 8'(acc_cnt), 1'b0);
      in_valid = 1'b1;
      acc_ok = in_ready;
      if (out_valid) begin
        if (seen && out_data != held) changes++;
        held = out_data; seen = 1'b1;
      end
      tick();
      if (acc_ok) acc_cnt++;
    end
    n_vec++; if (acc_cnt !== DEPTH) begin n_err++; $display("FAIL bp_accepted got %0d want 64", acc_cnt); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready got %0b want 0", in_ready); end
    n_vec++; if (in_flight !== 7'd64) begin n_err++; $display("FAIL bp_inflight got %0d want 64", in_flight); end
    n_vec++; if (changes !== 0) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", changes); end
    n_vec++; if (out_data !== 32'h4180_0000) begin n_err++; $display("FAIL bp_head_data got %h want 41800000", out_data); end
    // in_valid still high with id 64 pending; one drain, then accept+drain together.
    set_uniform(32'h3F80_0000, 32'h4000_0000, int_to_f32(64), 8'd64, 1'b0);
    out_ready = 1'b1;
    n_vec++; if (out_id !== 8'd0) begin n_err++; $display("FAIL cr_id0 got %0d want 0", out_id); end
    tick();
    n_vec++; if (in_flight !== 7'd63) begin n_err++; $display("FAIL cr_drain got %0d want 63", in_flight); end
    n_vec++; if (out_id !== 8'd1) begin n_err++; $display("FAIL cr_id1 got %0d want 1", out_id); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL cr_ready got %0b want 1", in_ready); end
    tick();
    n_vec++; if (in_flight !== 7'd63) begin n_err++; $display("FAIL cr_simul got %0d want 63", in_flight); end
    out_ready = 1'b0;
    set_uniform(32'h3F80_0000, 32'h4000_0000, int_to_f32(65), 8'd65, 1'b0);
    tick();
    in_valid = 1'b0;
    n_vec++; if (in_flight !== 7'd64) begin n_err++; $display("FAIL cr_full got %0d want 64", in_flight); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL cr_full_ready got %0b want 0", in_ready); end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 300 && got < 64; c++) begin
      if (out_valid) begin
        n_vec++; if (out_id !== 8'(got + 2)) begin n_err++; $display("FAIL cr_order got %0d want %0d", out_id, got + 2); end
        n_vec++; if (out_data !== int_to_f32(got + 18)) begin n_err++; $display("FAIL cr_data got %h want %h", out_data, int_to_f32(got + 18)); end
        got++;
      end
      tick();
    end
    out_ready = 1'b0;
    n_vec++; if (got !== 64) begin n_err++; $display("FAIL cr_count got %0d want 64", got); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL cr_end_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_reset_flight();
    int stale, lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_uniform(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 8'(100 + i), 1'b0);
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (in_flight !== 7'd20) begin n_err++; $display("FAIL rf_pre got %0d want 20", in_flight); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid got %0b want 0", out_valid); end
    n_vec++; if (in_flight !== 7'd0) begin n_err++; $display("FAIL rf_inflight got %0d want 0", in_flight); end
    stale = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) stale++;
      tick();
    end
    n_vec++; if (stale !== 0) begin n_err++; $display("FAIL rf_stale got %0d want 0", stale); end
    set_uniform(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 8'hAA, 1'b0);
    in_valid = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rf_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    n_vec++; if (lat !== L) begin n_err++; $display("FAIL rf_latency got %0d want %0d", lat, L); end
    n_vec++; if (out_data !== 32'h4184_0000) begin n_err++; $display("FAIL rf_data got %h want 41840000", out_data); end
    n_vec++; if (out_id !== 8'hAA) begin n_err++; $display("FAIL rf_id got %h want aa", out_id); end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_stream();
    test_backpressure();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
